// File: rtl/fpu_out_pkg.sv
// Shared CPX packet layout and per-pipe result field widths for the FPU output stage.
// cpx_pack builds a CPX return packet from one pipe result.
package fpu_out_pkg;

   localparam int         CPX_W       = 145;
   localparam logic [3:0] FP_RTYPE    = 4'b1000;
   localparam int         CPX_VLD_B   = 144;
   localparam int         CPX_RTYPE_LO = 140;
   localparam int         CPX_THR_LO  = 134;
   localparam int         CPX_EXC_LO  = 72;
   localparam int         CPX_CC_LO   = 64;
   localparam int         CPX_DATA_LO = 0;

   localparam int THR_W  = 2;
   localparam int EXC_W  = 5;
   localparam int CC_W   = 8;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic [THR_W-1:0]  thr;
      logic [EXC_W-1:0]  exc;
      logic [CC_W-1:0]   cc;
      logic [DATA_W-1:0] data;
   } pipe_res_t;

   function automatic logic [CPX_W-1:0] cpx_pack(input pipe_res_t r);
      logic [CPX_W-1:0] p;
      p                             = '0;
      p[CPX_VLD_B]                  = 1'b1;
      p[CPX_RTYPE_LO +: 4]          = FP_RTYPE;
      p[CPX_THR_LO   +: THR_W]      = r.thr;
      p[CPX_EXC_LO   +: EXC_W]      = r.exc;
      p[CPX_CC_LO    +: CC_W]       = r.cc;
      p[CPX_DATA_LO  +: DATA_W]     = r.data;
      return p;
   endfunction

endpackage

// File: rtl/fpu_out_q_if.sv
// Pipe-result and CPX-side signal bundle of the FPU output stage.
// master = pipes/CPX environment, slave = fpu_out_q.
interface fpu_out_q_if #(
   parameter int NPIPES = 3,
   parameter int CNTW   = 3
);
   import fpu_out_pkg::*;

   logic [NPIPES-1:0]        pipe_vld;
   logic [NPIPES-1:0]        pipe_rdy;
   logic [THR_W*NPIPES-1:0]  pipe_thread;
   logic [EXC_W*NPIPES-1:0]  pipe_exc;
   logic [CC_W*NPIPES-1:0]   pipe_cc;
   logic [DATA_W*NPIPES-1:0] pipe_data;
   logic                     cpx_fp_grant;
   logic                     fp_cpx_req;
   logic [CPX_W-1:0]         fp_cpx_data_ca;
   logic [CNTW-1:0]          q_cnt;
   logic                     err_grant_empty;

   modport master (
      output pipe_vld, pipe_thread, pipe_exc, pipe_cc, pipe_data, cpx_fp_grant,
      input  pipe_rdy, fp_cpx_req, fp_cpx_data_ca, q_cnt, err_grant_empty
   );

   modport slave (
      input  pipe_vld, pipe_thread, pipe_exc, pipe_cc, pipe_data, cpx_fp_grant,
      output pipe_rdy, fp_cpx_req, fp_cpx_data_ca, q_cnt, err_grant_empty
   );

endinterface

// File: rtl/fpu_out_arb.sv
// Result-pipe arbiter: fixed priority (highest index wins) or round-robin from ptr_i.
// Produces a one-hot grant and the pointer value following the winner.
module fpu_out_arb #(
   parameter int NPIPES   = 3,
   parameter int ARB_MODE = 0,
   parameter int PTRW     = (NPIPES > 1) ? $clog2(NPIPES) : 1
) (
   input  logic [NPIPES-1:0] req_i,
   input  logic [PTRW-1:0]   ptr_i,
   output logic [NPIPES-1:0] gnt_o,
   output logic [PTRW-1:0]   ptr_nxt_o
);

   logic [PTRW-1:0] win_s;
   logic [PTRW-1:0] idx_s;
   logic            found_s;
   logic            hit_s;

   // Fixed mode scans downward from the top pipe; round-robin scans upward from ptr_i with wrap.
   always_comb begin
      win_s   = '0;
      idx_s   = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      for (int k = 0; k < NPIPES; k++) begin
         idx_s   = (ARB_MODE == 0) ? PTRW'(NPIPES - 1 - k)
                                   : PTRW'((int'(ptr_i) + k) % NPIPES);
         hit_s   = !found_s && req_i[idx_s];
         win_s   = hit_s ? idx_s : win_s;
         found_s = found_s | hit_s;
      end
   end

   // One-hot grant and the wrapped successor of the winner.
   always_comb begin
      gnt_o     = found_s ? (NPIPES'(1) << win_s) : '0;
      ptr_nxt_o = (win_s == PTRW'(NPIPES - 1)) ? '0 : (win_s + PTRW'(1));
   end

endmodule

// File: rtl/fpu_out_q.sv
// FPU result output stage: arbitrates pipe results, packs them into CPX packets,
// queues them in a DEPTH-entry FIFO and pops the head to the CPX on grant.
module fpu_out_q
   import fpu_out_pkg::*;
#(
   parameter int NPIPES   = 3,
   parameter int DEPTH    = 4,
   parameter int ARB_MODE = 0,
   parameter int CNTW     = 3
) (
   input  logic        rclk,
   input  logic        rst_l,
   fpu_out_q_if.slave  bus
);

   localparam int AW   = $clog2(DEPTH);
   localparam int PTRW = (NPIPES > 1) ? $clog2(NPIPES) : 1;

   logic [CPX_W-1:0]  mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CPX_W-1:0]  data_q, data_d;
   logic              err_q, err_d;

   logic [NPIPES-1:0] arb_gnt_s;
   logic [PTRW-1:0]   arb_ptr_nxt_s;
   logic [NPIPES-1:0] rdy_s;
   logic              pop_s, push_s, space_s;
   pipe_res_t         win_res_s;

   fpu_out_arb #(
      .NPIPES   (NPIPES),
      .ARB_MODE (ARB_MODE),
      .PTRW     (PTRW)
   ) u_arb (
      .req_i     (bus.pipe_vld),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (arb_gnt_s),
      .ptr_nxt_o (arb_ptr_nxt_s)
   );

   // A full FIFO still accepts when the head leaves in the same cycle.
   always_comb begin
      pop_s   = bus.cpx_fp_grant & (cnt_q != '0);
      space_s = (cnt_q < CNTW'(DEPTH)) | pop_s;
      rdy_s   = (rst_l & space_s) ? arb_gnt_s : '0;
      push_s  = |rdy_s;
   end

   // Select the accepted pipe's fields via its one-hot ready bit.
   always_comb begin
      win_res_s = '0;
      for (int i = 0; i < NPIPES; i++) begin
         win_res_s.thr  = win_res_s.thr  | ({THR_W{rdy_s[i]}}  & bus.pipe_thread[i*THR_W  +: THR_W]);
         win_res_s.exc  = win_res_s.exc  | ({EXC_W{rdy_s[i]}}  & bus.pipe_exc[i*EXC_W     +: EXC_W]);
         win_res_s.cc   = win_res_s.cc   | ({CC_W{rdy_s[i]}}   & bus.pipe_cc[i*CC_W       +: CC_W]);
         win_res_s.data = win_res_s.data | ({DATA_W{rdy_s[i]}} & bus.pipe_data[i*DATA_W   +: DATA_W]);
      end
   end

   // Next-state for pointers, occupancy, output packet and error flag.
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNTW'(1);
         2'b01:   cnt_d = cnt_q - CNTW'(1);
         default: cnt_d = cnt_q;
      endcase
      rr_ptr_d = push_s ? arb_ptr_nxt_s : rr_ptr_q;
      data_d   = pop_s ? mem_q[rd_ptr_q] : '0;
      err_d    = err_q | (bus.cpx_fp_grant & (cnt_q == '0));
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge rclk) begin
      if (!rst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage; stale entries are unreachable once the pointers reset.
   always_ff @(posedge rclk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= cpx_pack(win_res_s);
      end
   end

   assign bus.pipe_rdy        = rdy_s;
   assign bus.fp_cpx_req      = (cnt_q != '0);
   assign bus.fp_cpx_data_ca  = data_q;
   assign bus.q_cnt           = cnt_q;
   assign bus.err_grant_empty = err_q;

endmodule

// File: tb/tb_fpu_out_q.sv
// Bench for fpu_out_q: fixed-priority and round-robin instances, packets checked against a scoreboard queue.
module tb_fpu_out_q;

   localparam int NP    = 3;
   localparam int DEPTH = 4;
   localparam int CNTW  = 3;

   logic rclk = 1'b0;
   logic rst_l;
   always #5 rclk = ~rclk;

   fpu_out_q_if #(.NPIPES(NP), .CNTW(CNTW)) if_fix ();
   fpu_out_q_if #(.NPIPES(NP), .CNTW(CNTW)) if_rr ();

   fpu_out_q #(.NPIPES(NP), .DEPTH(DEPTH), .ARB_MODE(0), .CNTW(CNTW)) u_fix (
      .rclk(rclk), .rst_l(rst_l), .bus(if_fix.slave));
   fpu_out_q #(.NPIPES(NP), .DEPTH(DEPTH), .ARB_MODE(1), .CNTW(CNTW)) u_rr (
      .rclk(rclk), .rst_l(rst_l), .bus(if_rr.slave));

   int n_checks = 0;
   int n_pass   = 0;
   logic [144:0] exp_q[$];
   logic [144:0] exp_v;

   logic [1:0]  thr_a  [NP];
   logic [4:0]  exc_a  [NP];
   logic [7:0]  cc_a   [NP];
   logic [63:0] data_a [NP];

   function automatic logic [144:0] mk_pkt(logic [1:0] thr, logic [4:0] exc, logic [7:0] cc, logic [63:0] d);
      logic [144:0] p;
      p = '0;
      p[144]     = 1'b1;
      p[143:140] = 4'h8;
      p[135:134] = thr;
      p[76:72]   = exc;
      p[71:64]   = cc;
      p[63:0]    = d;
      return p;
   endfunction

   task automatic set_pipe(int p, logic [1:0] thr, logic [4:0] exc, logic [7:0] cc, logic [63:0] d);
      thr_a[p] = thr; exc_a[p] = exc; cc_a[p] = cc; data_a[p] = d;
      if_fix.pipe_thread[p*2 +: 2] = thr;
      if_fix.pipe_exc[p*5 +: 5]    = exc;
      if_fix.pipe_cc[p*8 +: 8]     = cc;
      if_fix.pipe_data[p*64 +: 64] = d;
   endtask

   task automatic cycle();
      @(posedge rclk);
      @(negedge rclk);
   endtask

   task automatic test_reset();
      rst_l = 1'b0;
      if_fix.pipe_vld = 3'b111; if_fix.cpx_fp_grant = 1'b0;
      if_rr.pipe_vld = 3'b000; if_rr.cpx_fp_grant = 1'b0;
      if_fix.pipe_thread = '0; if_fix.pipe_exc = '0; if_fix.pipe_cc = '0; if_fix.pipe_data = '0;
      if_rr.pipe_thread = '0; if_rr.pipe_exc = '0; if_rr.pipe_cc = '0; if_rr.pipe_data = '0;
      repeat (2) @(posedge rclk);
      @(negedge rclk);
      n_checks++; if (if_fix.pipe_rdy !== 3'b000) $display("FAIL rdy_in_reset: got %b want 000", if_fix.pipe_rdy); else n_pass++;
      if_fix.pipe_vld = 3'b000;
      rst_l = 1'b1;
      cycle();
      n_checks++; if (if_fix.pipe_rdy !== 3'b000) $display("FAIL idle_rdy: got %b want 000", if_fix.pipe_rdy); else n_pass++;
      n_checks++; if (if_fix.fp_cpx_req !== 1'b0) $display("FAIL idle_req: got %b want 0", if_fix.fp_cpx_req); else n_pass++;
      n_checks++; if (if_fix.fp_cpx_data_ca !== 145'd0) $display("FAIL idle_data: got %h want 0", if_fix.fp_cpx_data_ca); else n_pass++;
      n_checks++; if (if_fix.q_cnt !== 3'd0) $display("FAIL idle_cnt: got %0d want 0", if_fix.q_cnt); else n_pass++;
      n_checks++; if (if_fix.err_grant_empty !== 1'b0) $display("FAIL idle_err: got %b want 0", if_fix.err_grant_empty); else n_pass++;
   endtask

   task automatic test_single();
      set_pipe(1, 2'b10, 5'h04, 8'h00, 64'h3FF0_0000_0000_0000);
      if_fix.pipe_vld = 3'b010;
      #1;
      n_checks++; if (if_fix.pipe_rdy !== 3'b010) $display("FAIL single_rdy: got %b want 010", if_fix.pipe_rdy); else n_pass++;
      exp_q.push_back(mk_pkt(thr_a[1], exc_a[1], cc_a[1], data_a[1]));
      cycle();
      if_fix.pipe_vld = 3'b000;
      n_checks++; if (if_fix.fp_cpx_req !== 1'b1) $display("FAIL single_req: got %b want 1", if_fix.fp_cpx_req); else n_pass++;
      n_checks++; if (if_fix.q_cnt !== 3'd1) $display("FAIL single_cnt: got %0d want 1", if_fix.q_cnt); else n_pass++;
      if_fix.cpx_fp_grant = 1'b1;
      cycle();
      if_fix.cpx_fp_grant = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++; if (if_fix.fp_cpx_data_ca !== exp_v) $display("FAIL single_pkt: got %h want %h", if_fix.fp_cpx_data_ca, exp_v); else n_pass++;
      n_checks++; if (if_fix.fp_cpx_data_ca[143:140] !== 4'h8) $display("FAIL single_rtype: got %h want 8", if_fix.fp_cpx_data_ca[143:140]); else n_pass++;
      n_checks++; if (if_fix.fp_cpx_data_ca[135:134] !== 2'd2) $display("FAIL single_thr: got %0d want 2", if_fix.fp_cpx_data_ca[135:134]); else n_pass++;
      n_checks++; if (if_fix.q_cnt !== 3'd0) $display("FAIL single_cnt0: got %0d want 0", if_fix.q_cnt); else n_pass++;
      cycle();
      n_checks++; if (if_fix.fp_cpx_data_ca !== 145'd0) $display("FAIL single_clr: got %h want 0", if_fix.fp_cpx_data_ca); else n_pass++;
   endtask

   task automatic test_fixed_prio();
      logic [2:0] pend;
      int w;
      for (int p = 0; p < NP; p++)
         set_pipe(p, 2'(p), 5'(p + 1), 8'(8'h10 + p), 64'hF1F0_0000_0000_0000 + 64'(p));
      pend = 3'b111;
      for (int k = 0; k < 3; k++) begin
         if_fix.pipe_vld = pend;
         #1;
         w = 2 - k;
         n_checks++; if (if_fix.pipe_rdy !== (3'b001 << w)) $display("FAIL prio_rdy%0d: got %b want %b", k, if_fix.pipe_rdy, 3'b001 << w); else n_pass++;
         exp_q.push_back(mk_pkt(thr_a[w], exc_a[w], cc_a[w], data_a[w]));
         pend[w] = 1'b0;
         cycle();
      end
      if_fix.pipe_vld = 3'b000;
      n_checks++; if (if_fix.q_cnt !== 3'd3) $display("FAIL prio_cnt3: got %0d want 3", if_fix.q_cnt); else n_pass++;
      set_pipe(0, 2'd3, 5'h1F, 8'hA5, 64'h0123_4567_89AB_CDEF);
      if_fix.pipe_vld = 3'b001;
      #1;
      n_checks++; if (if_fix.pipe_rdy !== 3'b001) $display("FAIL refill_rdy: got %b want 001", if_fix.pipe_rdy); else n_pass++;
      exp_q.push_back(mk_pkt(thr_a[0], exc_a[0], cc_a[0], data_a[0]));
      cycle();
      set_pipe(2, 2'd1, 5'h11, 8'h5A, 64'hDEAD_BEEF_0000_0002);
      if_fix.pipe_vld = 3'b100;
      #1;
      n_checks++; if (if_fix.q_cnt !== 3'd4) $display("FAIL full_cnt: got %0d want 4", if_fix.q_cnt); else n_pass++;
      n_checks++; if (if_fix.pipe_rdy !== 3'b000) $display("FAIL full_block: got %b want 000", if_fix.pipe_rdy); else n_pass++;
      cycle();
      n_checks++; if (if_fix.q_cnt !== 3'd4) $display("FAIL full_hold: got %0d want 4", if_fix.q_cnt); else n_pass++;
      if_fix.cpx_fp_grant = 1'b1;
      #1;
      n_checks++; if (if_fix.pipe_rdy !== 3'b100) $display("FAIL full_pushpop_rdy: got %b want 100", if_fix.pipe_rdy); else n_pass++;
      exp_q.push_back(mk_pkt(thr_a[2], exc_a[2], cc_a[2], data_a[2]));
      cycle();
      if_fix.pipe_vld = 3'b000;
      n_checks++; if (if_fix.q_cnt !== 3'd4) $display("FAIL full_pushpop_cnt: got %0d want 4", if_fix.q_cnt); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) cycle();
         exp_v = exp_q.pop_front();
         n_checks++; if (if_fix.fp_cpx_data_ca !== exp_v) $display("FAIL drain%0d: got %h want %h", k, if_fix.fp_cpx_data_ca, exp_v); else n_pass++;
      end
      if_fix.cpx_fp_grant = 1'b0;
      n_checks++; if (if_fix.q_cnt !== 3'd0 || if_fix.fp_cpx_req !== 1'b0) $display("FAIL drain_empty: got cnt=%0d req=%b want 0/0", if_fix.q_cnt, if_fix.fp_cpx_req); else n_pass++;
      cycle();
      n_checks++; if (if_fix.fp_cpx_data_ca !== 145'd0) $display("FAIL drain_clr: got %h want 0", if_fix.fp_cpx_data_ca); else n_pass++;
   endtask

   task automatic test_back_to_back_q1();
      set_pipe(1, 2'd1, 5'h02, 8'h33, 64'h1111_2222_3333_4444);
      if_fix.pipe_vld = 3'b010;
      #1;
      exp_q.push_back(mk_pkt(thr_a[1], exc_a[1], cc_a[1], data_a[1]));
      cycle();
      set_pipe(0, 2'd0, 5'h08, 8'h44, 64'h5555_6666_7777_8888);
      if_fix.pipe_vld = 3'b001;
      if_fix.cpx_fp_grant = 1'b1;
      #1;
      n_checks++; if (if_fix.pipe_rdy !== 3'b001) $display("FAIL q1_rdy: got %b want 001", if_fix.pipe_rdy); else n_pass++;
      exp_q.push_back(mk_pkt(thr_a[0], exc_a[0], cc_a[0], data_a[0]));
      cycle();
      if_fix.pipe_vld = 3'b000;
      exp_v = exp_q.pop_front();
      n_checks++; if (if_fix.fp_cpx_data_ca !== exp_v) $display("FAIL q1_pkt0: got %h want %h", if_fix.fp_cpx_data_ca, exp_v); else n_pass++;
      n_checks++; if (if_fix.q_cnt !== 3'd1 || if_fix.fp_cpx_req !== 1'b1) $display("FAIL q1_cnt: got cnt=%0d req=%b want 1/1", if_fix.q_cnt, if_fix.fp_cpx_req); else n_pass++;
      cycle();
      if_fix.cpx_fp_grant = 1'b0;
      exp_v = exp_q.pop_front();
      n_checks++; if (if_fix.fp_cpx_data_ca !== exp_v) $display("FAIL q1_pkt1: got %h want %h", if_fix.fp_cpx_data_ca, exp_v); else n_pass++;
      cycle();
      n_checks++; if (if_fix.fp_cpx_data_ca !== 145'd0) $display("FAIL q1_clr: got %h want 0", if_fix.fp_cpx_data_ca); else n_pass++;
   endtask

   task automatic test_grant_empty();
      n_checks++; if (if_fix.err_grant_empty !== 1'b0) $display("FAIL err_pre: got %b want 0", if_fix.err_grant_empty); else n_pass++;
      if_fix.cpx_fp_grant = 1'b1;
      cycle();
      if_fix.cpx_fp_grant = 1'b0;
      n_checks++; if (if_fix.fp_cpx_data_ca !== 145'd0) $display("FAIL empty_data: got %h want 0", if_fix.fp_cpx_data_ca); else n_pass++;
      n_checks++; if (if_fix.q_cnt !== 3'd0) $display("FAIL empty_cnt: got %0d want 0", if_fix.q_cnt); else n_pass++;
      n_checks++; if (if_fix.err_grant_empty !== 1'b1) $display("FAIL err_set: got %b want 1", if_fix.err_grant_empty); else n_pass++;
      repeat (3) cycle();
      n_checks++; if (if_fix.err_grant_empty !== 1'b1) $display("FAIL err_sticky: got %b want 1", if_fix.err_grant_empty); else n_pass++;
      rst_l = 1'b0;
      cycle();
      rst_l = 1'b1;
      n_checks++; if (if_fix.err_grant_empty !== 1'b0) $display("FAIL err_clr: got %b want 0", if_fix.err_grant_empty); else n_pass++;
   endtask

   task automatic test_reset_flush();
      logic [2:0] pend;
      for (int p = 0; p < NP; p++)
         set_pipe(p, 2'(p), 5'h03, 8'h77, 64'hBAD0_0000_0000_0000 + 64'(p));
      pend = 3'b111;
      for (int k = 0; k < 3; k++) begin
         if_fix.pipe_vld = pend;
         pend[2 - k] = 1'b0;
         cycle();
      end
      if_fix.pipe_vld = 3'b000;
      n_checks++; if (if_fix.q_cnt !== 3'd3) $display("FAIL flush_pre: got %0d want 3", if_fix.q_cnt); else n_pass++;
      rst_l = 1'b0;
      cycle();
      rst_l = 1'b1;
      n_checks++; if (if_fix.q_cnt !== 3'd0 || if_fix.fp_cpx_req !== 1'b0) $display("FAIL flush_cnt: got cnt=%0d req=%b want 0/0", if_fix.q_cnt, if_fix.fp_cpx_req); else n_pass++;
      if_fix.cpx_fp_grant = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         n_checks++; if (if_fix.fp_cpx_data_ca !== 145'd0) $display("FAIL flush_leak%0d: got %h want 0", k, if_fix.fp_cpx_data_ca); else n_pass++;
      end
      if_fix.cpx_fp_grant = 1'b0;
   endtask

   task automatic test_round_robin();
      int m_cnt = 0;
      logic pop_prev = 1'b0;
      int seq[NP] = '{0, 0, 0};
      int w;
      logic [63:0] d;
      for (int k = 0; k < 9; k++) begin
         @(negedge rclk);
         if (k > 0) begin
            exp_v = pop_prev ? exp_q.pop_front() : 145'd0;
            n_checks++; if (if_rr.fp_cpx_data_ca !== exp_v) $display("FAIL rr_out%0d: got %h want %h", k, if_rr.fp_cpx_data_ca, exp_v); else n_pass++;
         end
         for (int p = 0; p < NP; p++) begin
            if_rr.pipe_thread[p*2 +: 2]  = 2'(p);
            if_rr.pipe_exc[p*5 +: 5]     = 5'(p + 8);
            if_rr.pipe_cc[p*8 +: 8]      = 8'h00;
            if_rr.pipe_data[p*64 +: 64]  = 64'hC0DE_0000_0000_0000 | (64'(p) << 16) | 64'(seq[p]);
         end
         if_rr.pipe_vld = (k < 6) ? 3'b111 : 3'b000;
         pop_prev = (m_cnt > 0);
         if_rr.cpx_fp_grant = pop_prev;
         #1;
         if (k < 6) begin
            w = k % 3;
            n_checks++; if (if_rr.pipe_rdy !== (3'b001 << w)) $display("FAIL rr_rdy%0d: got %b want %b", k, if_rr.pipe_rdy, 3'b001 << w); else n_pass++;
            d = 64'hC0DE_0000_0000_0000 | (64'(w) << 16) | 64'(seq[w]);
            exp_q.push_back(mk_pkt(2'(w), 5'(w + 8), 8'h00, d));
            seq[w]++;
            m_cnt++;
         end
         if (pop_prev) m_cnt--;
      end
      if_rr.pipe_vld = 3'b110;
      if_rr.cpx_fp_grant = 1'b0;
      #1;
      n_checks++; if (if_rr.pipe_rdy !== 3'b010) $display("FAIL rr_ptr_hold: got %b want 010", if_rr.pipe_rdy); else n_pass++;
      if_rr.pipe_vld = 3'b000;
      n_checks++; if (if_rr.q_cnt !== 3'd0) $display("FAIL rr_cnt: got %0d want 0", if_rr.q_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fixed_prio();
      test_back_to_back_q1();
      test_grant_empty();
      test_reset_flush();
      test_round_robin();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
